sobel_window_3x3: RTL and testbench
===================================

Name: sobel_window_3x3

Overview:
Upstream feeder for the deterministic 3x3 Sobel core. Accepts a raster-order 8-bit pixel stream and keeps two line buffers plus a 3x3 shift window. For every interior pixel position it presents the nine neighbourhood pixels z1..z9 to the Sobel core. It has no border padding, so it emits (W-2)*(H-2) windows per frame.

Parameters:
IMG_WIDTH, 64, pixels per line (>=3); sets line-buffer depth and column counter range
IMG_HEIGHT, 64, lines per frame (>=3); sets row counter range and out_eof position

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
in_pix  in  8  input pixel, raster order
in_valid  in  1  in_pix valid
in_sof  in  1  start of frame; qualifies in_pix as pixel (0,0)
in_ready  out  1  block can accept in_pix this cycle
z1..z9  out  8 each  window; z1=(r-2,c-2), z2=(r-2,c-1), z3=(r-2,c), z4..z6 row r-1, z7..z9 row r; z9 = newest pixel
out_valid  out  1  window valid
out_eof  out  1  with out_valid: last window of frame (r=H-1, c=W-1)
out_ready  in  1  consumer accepts window
err_sof  out  1  sticky: in_sof seen with counters not at (0,0); only under the optional macro

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, rst_n. While asserted, z1..z9, out_valid, out_eof, err_sof, col_cnt and row_cnt are all 0. Line-buffer RAM is not reset; stale contents are never exposed because out_valid gates them.
- Handshake: in_ready = !out_valid || out_ready, combinational. A pixel is accepted when in_valid && in_ready.
- Stall: while out_valid && !out_ready, z1..z9, out_valid and out_eof hold stable and no pixel is accepted.
- On accept, with (r,c) the current counters:
  - The window shifts left by one column. The new right column is {linebuf1[c], linebuf0[c], in_pix} into z3, z6, z9.
  - linebuf1[c] <= linebuf0[c]; linebuf0[c] <= in_pix.
  - out_valid <= (r>=2 && c>=2); out_eof <= (r==H-1 && c==W-1).
  - Counters advance. col wraps W-1 -> 0 with row++. Row wraps H-1 -> 0, which implicitly starts the next frame.
- If in_sof accompanies an accepted pixel: treat it as (0,0). The window and line buffers shift normally; counters are forced so the next pixel is (0,1). Any partial frame is abandoned.
- No accept but out_ready && out_valid: out_valid <= 0, out_eof <= 0.
- Latency: window updated 1 cycle after the accept of its z9 pixel. Full throughput is 1 pixel/cycle with out_ready held high.
- Gaps on in_valid are allowed anywhere; state holds.
- Arithmetic: col_cnt is clog2(W) bits and row_cnt is clog2(H) bits, both unsigned, with explicit compare-and-wrap (no power-of-two assumption).
- Reset mid-frame: counters return to (0,0); the next accepted pixel is (0,0) regardless of in_sof.

Optional Feature:
Macro SOBEL_WIN_SOF_CHECK_EN.
- Defined: err_sof is set when in_sof is accepted and (r,c) != (0,0). It stays set until rst_n.
- Not defined: err_sof is tied 0 and the check logic is absent. Resync on in_sof behaves the same in both cases.

Decomposition:
- Shared package sobel_pkg: PIX_W=8 constant, pixel_t (logic [7:0]), win_t (array of 9 pixel_t), MIN_DIM=3.
- One natural sub-module: sobel_line_buffer. It is a simple synchronous read-before-write RAM of depth IMG_WIDTH x 8, instantiated twice or once with 16-bit width.
- The counter logic, window and handshake stay in the top.

Test Plan:
- W=H=4, pixels 0..15 streamed with out_ready=1 and in_sof on pixel 0 -> first out_valid one cycle after pixel 10 with z1..z9 = 0,1,2,4,5,6,8,9,10. Exactly 4 windows are produced; the last has z9=15, z5=10 and out_eof=1.
- Same stream with out_ready=0 for 5 cycles after the first window -> in_ready=0, z1..z9 held, no pixel lost. The remaining 3 windows are correct after release.
- Random in_valid gaps (50% duty), 8x6 image -> window sequence matches a software model; 24 windows total.
- in_sof asserted at pixel 7 of a 4x4 frame, then 16 pixels -> output resynchronises to that pixel as (0,0) and gives 4 correct windows. err_sof=1 if the macro is defined, else 0.
- rst_n pulsed low mid-frame (asynchronously, not clock-aligned) -> outputs go to 0 immediately. The next 16 pixels without in_sof produce 4 correct windows.
- Two back-to-back 4x4 frames, no in_sof on the second -> 8 windows, out_eof on the 4th and 8th.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared pixel and window types for the 3x3 Sobel window feeder.
package sobel_pkg;
  localparam int PIX_W   = 8;
  localparam int MIN_DIM = 3;

  typedef logic [PIX_W-1:0] pixel_t;
  // Index 0 is z1 (oldest, top-left), index 8 is z9 (newest pixel).
  typedef logic [8:0][PIX_W-1:0] win_t;
endpackage

// File: rtl/sobel_window_3x3_if.sv
// Pixel-in / window-out stream bundle between a pixel source, the window feeder and the Sobel core.
interface sobel_window_3x3_if;
  import sobel_pkg::*;

  pixel_t in_pix;
  logic   in_valid;
  logic   in_sof;
  logic   in_ready;
  pixel_t z1, z2, z3, z4, z5, z6, z7, z8, z9;
  logic   out_valid;
  logic   out_eof;
  logic   out_ready;
  logic   err_sof;

  modport master (
    output in_pix, in_valid, in_sof, out_ready,
    input  in_ready, z1, z2, z3, z4, z5, z6, z7, z8, z9, out_valid, out_eof, err_sof
  );

  modport slave (
    input  in_pix, in_valid, in_sof, out_ready,
    output in_ready, z1, z2, z3, z4, z5, z6, z7, z8, z9, out_valid, out_eof, err_sof
  );
endinterface

// File: rtl/sobel_line_buffer.sv
// Line buffer RAM: synchronous write, registered read returning contents from before a same-cycle write.
module sobel_line_buffer #(
  parameter int  DEPTH = 64,
  parameter int  DW    = 16,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/sobel_window_3x3.sv
// 3x3 raster window generator for the Sobel core; one window per interior pixel, no border padding.
// Build macro SOBEL_WIN_SOF_CHECK_EN adds the sticky err_sof flag for misaligned start-of-frame.
module sobel_window_3x3
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input logic               clk,
  input logic               rst_n,
  sobel_window_3x3_if.slave bus
);
  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  win_t               win_q, win_d;
  logic               out_valid_q, out_valid_d;
  logic               out_eof_q, out_eof_d;
  logic [COL_W-1:0]   col_q, col_d, col_eff;
  logic [ROW_W-1:0]   row_q, row_d, row_eff;
  logic [2*PIX_W-1:0] lb_rd, lb_wr;
  logic               in_ready;
  logic               accept;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;
  assign col_eff  = bus.in_sof ? '0 : col_q;
  assign row_eff  = bus.in_sof ? '0 : row_q;
  // Upper byte is the row two lines back, lower byte the previous row.
  assign lb_wr    = {lb_rd[PIX_W-1:0], bus.in_pix};

  // Read address tracks the next column so the registered read is ready at the next accept.
  sobel_line_buffer #(
    .DEPTH (IMG_WIDTH),
    .DW    (2 * PIX_W)
  ) u_line_buffer (
    .clk     (clk),
    .we_i    (accept),
    .waddr_i (col_eff),
    .wdata_i (lb_wr),
    .raddr_i (col_d),
    .rdata_o (lb_rd)
  );

  always_comb begin
    win_d       = win_q;
    out_valid_d = out_valid_q;
    out_eof_d   = out_eof_q;
    col_d       = col_q;
    row_d       = row_q;
    if (accept) begin
      for (int i = 0; i < 3; i++) begin
        win_d[3*i]   = win_q[3*i+1];
        win_d[3*i+1] = win_q[3*i+2];
      end
      win_d[2]    = lb_rd[2*PIX_W-1:PIX_W];
      win_d[5]    = lb_rd[PIX_W-1:0];
      win_d[8]    = bus.in_pix;
      out_valid_d = (row_eff >= ROW_W'(2)) && (col_eff >= COL_W'(2));
      out_eof_d   = (row_eff == ROW_LAST) && (col_eff == COL_LAST);
      if (col_eff == COL_LAST) begin
        col_d = '0;
        row_d = (row_eff == ROW_LAST) ? '0 : row_eff + 1'b1;
      end else begin
        col_d = col_eff + 1'b1;
        row_d = row_eff;
      end
    end else if (bus.out_ready && out_valid_q) begin
      out_valid_d = 1'b0;
      out_eof_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q       <= '0;
      out_valid_q <= 1'b0;
      out_eof_q   <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
    end else begin
      win_q       <= win_d;
      out_valid_q <= out_valid_d;
      out_eof_q   <= out_eof_d;
      col_q       <= col_d;
      row_q       <= row_d;
    end
  end

`ifdef SOBEL_WIN_SOF_CHECK_EN
  logic err_sof_q, err_sof_d;

  assign err_sof_d = err_sof_q ||
                     (accept && bus.in_sof && ((row_q != '0) || (col_q != '0)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sof_q <= 1'b0;
    end else begin
      err_sof_q <= err_sof_d;
    end
  end

  assign bus.err_sof = err_sof_q;
`else
  assign bus.err_sof = 1'b0;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_eof   = out_eof_q;
  assign bus.z1 = win_q[0];
  assign bus.z2 = win_q[1];
  assign bus.z3 = win_q[2];
  assign bus.z4 = win_q[3];
  assign bus.z5 = win_q[4];
  assign bus.z6 = win_q[5];
  assign bus.z7 = win_q[6];
  assign bus.z8 = win_q[7];
  assign bus.z9 = win_q[8];
endmodule

// File: tb/tb_sobel_window_3x3.sv
// Scoreboard bench: a 4x4 and an 8x6 window feeder driven from one stimulus process,
// checked against an image-array reference model.
module tb_sobel_window_3x3;
  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pix   = 8'd0;
  logic       vld   = 1'b0;
  logic       sof   = 1'b0;
  logic       ordy  = 1'b1;
  logic       sel   = 1'b0;

  int checks   = 0;
  int failures = 0;
  int win_cnt  = 0;
  int eof_cnt  = 0;
  int stall_left = 0;

  typedef struct packed {
    logic [71:0] zz;
    logic        eof;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] img [8][8];
  int mr = 0, mc = 0, cur_w = 4, cur_h = 4;

  always #5 clk = ~clk;

  sobel_window_3x3_if bus_a();
  sobel_window_3x3_if bus_b();

  sobel_window_3x3 #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  sobel_window_3x3 #(.IMG_WIDTH(8), .IMG_HEIGHT(6)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  assign bus_a.in_pix    = pix;
  assign bus_a.in_valid  = vld & ~sel;
  assign bus_a.in_sof    = sof;
  assign bus_a.out_ready = sel ? 1'b1 : ordy;
  assign bus_b.in_pix    = pix;
  assign bus_b.in_valid  = vld & sel;
  assign bus_b.in_sof    = sof;
  assign bus_b.out_ready = sel ? ordy : 1'b1;

  logic [71:0] m_zz;
  logic        m_valid, m_eof, m_in_ready, m_err;
  assign m_zz = sel ? {bus_b.z1, bus_b.z2, bus_b.z3, bus_b.z4, bus_b.z5, bus_b.z6, bus_b.z7, bus_b.z8, bus_b.z9}
                    : {bus_a.z1, bus_a.z2, bus_a.z3, bus_a.z4, bus_a.z5, bus_a.z6, bus_a.z7, bus_a.z8, bus_a.z9};
  assign m_valid    = sel ? bus_b.out_valid : bus_a.out_valid;
  assign m_eof      = sel ? bus_b.out_eof   : bus_a.out_eof;
  assign m_in_ready = sel ? bus_b.in_ready  : bus_a.in_ready;
  assign m_err      = sel ? bus_b.err_sof   : bus_a.err_sof;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
    end
  endtask

  // Reference: keep the frame as a 2D image and cut the 3x3 neighbourhood directly.
  task automatic model_accept(input logic [7:0] p, input logic s, output bit ev);
    exp_t e;
    if (s) begin
      mr = 0;
      mc = 0;
    end
    img[mr][mc] = p;
    ev = (mr >= 2 && mc >= 2);
    if (ev) begin
      e.zz = '0;
      for (int dr = 0; dr < 3; dr++)
        for (int dc = 0; dc < 3; dc++)
          e.zz = {e.zz[63:0], img[mr-2+dr][mc-2+dc]};
      e.eof = (mr == cur_h - 1 && mc == cur_w - 1);
      exp_q.push_back(e);
    end
    mc++;
    if (mc == cur_w) begin
      mc = 0;
      mr++;
      if (mr == cur_h) mr = 0;
    end
  endtask

  task automatic tick();
    if (stall_left > 0) begin
      stall_left--;
      if (stall_left == 0) ordy = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      tick();
    end
  endtask

  task automatic send_pix(input logic [7:0] p, input logic s);
    bit done = 0;
    bit ev   = 0;
    bit rdy;
    int n    = 0;
    pix = p;
    sof = s;
    vld = 1'b1;
    while (!done) begin
      @(negedge clk);
      rdy = m_in_ready;
      @(posedge clk);
      if (rdy) begin
        done = 1;
        model_accept(p, s, ev);
      end
      #1;
      tick();
      if (done) begin
        $display("pix %0h sof=%0d accepted, window expected=%0d", p, s, ev);
        chk("valid latency", 72'(m_valid), 72'(ev));
      end else if (++n > 100) begin
        chk("accept timeout", 72'(0), 72'(1));
        done = 1;
      end
    end
    vld = 1'b0;
    sof = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || stall_left != 0) && n < 200) begin
      @(posedge clk);
      #1;
      tick();
      n++;
    end
    chk({name, " drained"}, 72'(exp_q.size()), 72'(0));
    ordy = 1'b1;
    stall_left = 0;
    idle(2);
    chk({name, " idle valid"}, 72'(m_valid), 72'(0));
  endtask

  // Window monitor: a transfer happens on the posedge following a negedge with valid && ready.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n && m_valid && ordy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected window", 72'(1), 72'(0));
      end else begin
        e = exp_q.pop_front();
        $display("window z=%018h eof=%0d (exp z=%018h eof=%0d)", m_zz, m_eof, e.zz, e.eof);
        chk("window z", m_zz, e.zz);
        chk("window eof", 72'(m_eof), 72'(e.eof));
        win_cnt++;
        if (m_eof) eof_cnt++;
      end
    end
  end

  // Stall monitor: while the consumer refuses, the window holds and no pixel may enter.
  initial begin
    logic [72:0] prev = '0;
    bit prev_stall = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 0;
      end else if (m_valid && !ordy) begin
        chk("stall in_ready", 72'(m_in_ready), 72'(0));
        if (prev_stall) chk("stall hold", {m_zz}, prev[72:1]);
        if (prev_stall) chk("stall hold eof", 72'(m_eof), 72'(prev[0]));
        prev = {m_zz, m_eof};
        prev_stall = 1;
      end else begin
        prev_stall = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, e0;
    bit exp_err;
    logic [7:0] rp;
`ifdef SOBEL_WIN_SOF_CHECK_EN
    exp_err = 1;
`else
    exp_err = 0;
`endif
    // Reset state
    #22;
    chk("reset valid", 72'(m_valid), 72'(0));
    chk("reset eof", 72'(m_eof), 72'(0));
    chk("reset z", m_zz, 72'(0));
    chk("reset err", 72'(m_err), 72'(0));
    chk("reset in_ready", 72'(m_in_ready), 72'(1));
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // T1: 4x4 ramp, full throughput
    w0 = win_cnt; e0 = eof_cnt;
    for (int i = 0; i < 16; i++) send_pix(8'(i), i == 0);
    drain("t1");
    chk("t1 windows", 72'(win_cnt - w0), 72'(4));
    chk("t1 eofs", 72'(eof_cnt - e0), 72'(1));
    chk("t1 err", 72'(m_err), 72'(0));

    // T2: consumer stalls 5 cycles after the first window
    w0 = win_cnt;
    for (int i = 0; i < 16; i++) begin
      send_pix(8'(i), i == 0);
      if (i == 10) begin
        ordy = 1'b0;
        stall_left = 5;
      end
    end
    drain("t2");
    chk("t2 windows", 72'(win_cnt - w0), 72'(4));

    // T4: partial frame, then resync on in_sof
    w0 = win_cnt;
    for (int i = 0; i < 7; i++) send_pix(8'(100 + i), 1'b0);
    for (int i = 0; i < 16; i++) send_pix(8'($urandom), i == 0);
    drain("t4");
    chk("t4 windows", 72'(win_cnt - w0), 72'(4));
    chk("t4 err", 72'(m_err), 72'(exp_err));

    // T5: asynchronous reset mid-frame with a window pending
    for (int i = 0; i < 11; i++) send_pix(8'($urandom), 1'b0);
    chk("t5 pre-reset valid", 72'(m_valid), 72'(1));
    #2 rst_n = 1'b0;
    exp_q.delete();
    mr = 0;
    mc = 0;
    #1;
    chk("t5 async valid", 72'(m_valid), 72'(0));
    chk("t5 async z", m_zz, 72'(0));
    chk("t5 async err", 72'(m_err), 72'(0));
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    w0 = win_cnt;
    for (int i = 0; i < 16; i++) send_pix(8'($urandom), 1'b0);
    drain("t5");
    chk("t5 windows", 72'(win_cnt - w0), 72'(4));

    // T6: two back-to-back frames, no in_sof on the second
    w0 = win_cnt; e0 = eof_cnt;
    for (int i = 0; i < 32; i++) send_pix(8'($urandom), i == 0);
    drain("t6");
    chk("t6 windows", 72'(win_cnt - w0), 72'(8));
    chk("t6 eofs", 72'(eof_cnt - e0), 72'(2));

    // T3: 8x6 image with random input gaps and random consumer stalls
    sel = 1'b1;
    cur_w = 8;
    cur_h = 6;
    mr = 0;
    mc = 0;
    idle(1);
    w0 = win_cnt; e0 = eof_cnt;
    for (int i = 0; i < 48; i++) begin
      idle($urandom_range(0, 1));
      if (stall_left == 0 && $urandom_range(0, 3) == 0) begin
        ordy = 1'b0;
        stall_left = $urandom_range(1, 3);
      end
      rp = 8'($urandom);
      send_pix(rp, i == 0);
    end
    drain("t3");
    chk("t3 windows", 72'(win_cnt - w0), 72'(24));
    chk("t3 eofs", 72'(eof_cnt - e0), 72'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
